mult_div_unit: RTL and testbench
================================

# mult_div_unit

Iterative multiply/divide unit for the CPU execute stage. It takes the two operands produced by the execute-stage operand muxes and computes a 2·WIDTH-bit product, or a quotient/remainder pair, at one bit per clock. Results are held in internal HI/LO registers that feed the writeback select mux. A start/busy/done handshake lets the pipeline control logic stall while an operation is in flight.

## Interface
- `SIZE`, default 32: operand width; HI and LO are each SIZE bits.
- `clk`  in  1: rising-edge clock.
- `reset`  in  1: asynchronous, active-low reset (0 = reset asserted).
- `start`  in  1: request an operation; sampled on a rising edge of `clk`.
- `op`  in  2: 00 MULTU, 01 MULT, 10 DIVU, 11 DIV.
- `A`  in  SIZE: multiplicand / dividend.
- `B`  in  SIZE: multiplier / divisor.
- `busy`  out  1: operation in flight; new `start` is ignored.
- `done`  out  1: one-cycle pulse; `hi`/`lo`/`divzero` updated on the same edge.
- `hi`  out  SIZE: MULT upper product half; DIV remainder.
- `lo`  out  SIZE: MULT lower product half; DIV quotient.
- `divzero`  out  1: last completed operation was a divide with B == 0; held until the next `done`.

## Operation
- States: IDLE, RUN.
  - IDLE→RUN when `start`=1.
  - RUN→IDLE after SIZE iterations.
  - No other transitions.
- Accept: `start` sampled in IDLE latches `op`, A, B into internal registers. Input changes after that edge have no effect.
- `start` while in RUN is ignored (it is not queued).
- Signed ops (MULT, DIV):
  - Operands are converted to magnitudes and processed unsigned.
  - Product and quotient are negated when the operand signs differ.
  - Remainder takes the dividend's sign.
- Multiply: shift-add, one multiplier bit per cycle; 2·SIZE-bit accumulator.
- Divide: restoring, one quotient bit per cycle; SIZE+1-bit partial remainder.
- Divide by zero:
  - Still runs the full SIZE cycles (fixed latency).
  - Result: lo = all ones, hi = A unchanged, `divzero`=1.
- Signed overflow (DIV, A = most-negative value, B = -1): lo = 0x80000000, hi = 0 (SIZE=32), `divzero`=0.
- HI/LO change only on the `done` edge. No other path writes them.
- Reset values (asynchronous, `reset`=0): state IDLE, `busy`=0, `done`=0, `hi`=0, `lo`=0, `divzero`=0, iteration counter 0.
- Reset mid-operation aborts the operation; no `done` is produced for it.

## Timing
- `start` accepted at edge k:
  - `busy`=1 from edge k to edge k+SIZE.
  - At edge k+SIZE: `busy`→0, `done`→1, and `hi`/`lo`/`divzero` take their new values.
- Latency is SIZE cycles for every op, including divide by zero.
- `done` is high for exactly one cycle (k+SIZE to k+SIZE+1).
- Back-to-back: `start` sampled at edge k+SIZE+1, with `done` high and `busy` low, is accepted. Throughput is one op per SIZE+1 cycles.
- Outputs are registered; no combinational path from inputs to outputs.

## Configuration
- Macro `MULTDIV_DIV_EN`.
- Defined: full behaviour above, including the divider datapath and `divzero`.
- Undefined:
  - The divider datapath is not built and `divzero` is tied to 0.
  - `start` with `op[1]`=1 is ignored: no state change, `busy` stays 0, no `done`, HI/LO unchanged.
  - Multiply behaviour and timing are identical to the defined case.

## Test plan
- MULTU, A=0xFFFFFFFF, B=0xFFFFFFFF → hi=0xFFFFFFFE, lo=0x00000001; `done` exactly 32 cycles after the start edge; `busy` high for those 32 cycles.
- MULT, A=-3 (0xFFFFFFFD), B=7 → hi=0xFFFFFFFF, lo=0xFFFFFFEB.
- DIVU, A=100, B=7 → lo=14, hi=2.
- DIV, A=-7, B=2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIV, A=0x80000000, B=0xFFFFFFFF → lo=0x80000000, hi=0.
- DIVU, A=5, B=0 → lo=0xFFFFFFFF, hi=5, `divzero`=1. The next MULTU clears `divzero` at its `done`.
- Handshake:
  - `start` pulsed at cycle 5 of a running op → ignored, single `done`.
  - `start` in the `done` cycle → second op accepted, second `done` 32 cycles later.
  - `reset` driven low mid-RUN → `busy`, `done`, `hi`, `lo` go to 0 immediately, with no clock edge; no `done` follows.
- `MULTDIV_DIV_EN` undefined: DIVU start → `busy` stays 0, no `done`, hi/lo keep prior MULTU values; a following MULTU 6×7 → lo=42, hi=0.

Source files
------------

// File: rtl/mult_div_unit.sv
// mult_div_unit: iterative multiply/divide unit for the execute stage.
//
// Computes a 2*SIZE-bit product (MULTU/MULT) or quotient/remainder
// (DIVU/DIV) at one bit per clock. Every operation takes exactly SIZE
// cycles. Results land in the HI/LO registers on the single done edge.
//
// Optional feature macro: MULTDIV_DIV_EN
//   defined   - divider datapath built, divzero reported.
//   undefined - multiply only; starts with op[1]=1 are ignored and
//               divzero is tied to 0.
//
// Ports:
//   clk      in   rising-edge clock
//   reset    in   asynchronous reset, active low
//   start    in   operation request, sampled in IDLE only
//   op[1:0]  in   00 MULTU, 01 MULT, 10 DIVU, 11 DIV
//   A, B     in   operands (multiplicand/multiplier, dividend/divisor)
//   busy     out  operation in flight
//   done     out  one-cycle completion pulse
//   hi, lo   out  product halves, or remainder/quotient
//   divzero  out  last completed op was a divide by zero
module mult_div_unit #(
    parameter int SIZE = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [1:0]      op,
    input  logic [SIZE-1:0] A,
    input  logic [SIZE-1:0] B,
    output logic            busy,
    output logic            done,
    output logic [SIZE-1:0] hi,
    output logic [SIZE-1:0] lo,
    output logic            divzero
);

`ifdef MULTDIV_DIV_EN
    localparam bit DIV_EN = 1'b1;
`else
    localparam bit DIV_EN = 1'b0;
`endif
    localparam int CW = (SIZE > 1) ? $clog2(SIZE) : 1;

    typedef enum logic {IDLE, RUN} state_t;

    state_t            state;
    logic [CW-1:0]     cnt;
    logic [2*SIZE-1:0] acc;      // multiply: {partial sum, multiplier}; divide: lower half = dividend/quotient
    logic [SIZE-1:0]   mcand;    // |A| for multiply, |B| (divisor) for divide
    logic              neg_res;  // product/quotient must be negated

    logic              accept;
    logic              last;
    logic              sa, sb;
    logic [SIZE-1:0]   mag_a, mag_b;
    logic [SIZE:0]     sum;
    logic [2*SIZE-1:0] acc_nx;
    logic [2*SIZE-1:0] prod;
    logic [SIZE-1:0]   res_hi, res_lo;

`ifdef MULTDIV_DIV_EN
    logic              is_div;
    logic              neg_rem;  // remainder follows the dividend's sign
    logic              b_zero;
    logic [SIZE-1:0]   a_raw;    // unmodified dividend, returned in hi on divide by zero
    logic [SIZE-1:0]   rem;
    logic [SIZE:0]     shifted;  // SIZE+1-bit partial remainder under trial
    logic              ge;
    logic [SIZE-1:0]   rem_nx;
    logic [SIZE-1:0]   q_nx;
    logic              res_dz;
`endif

    // Divide ops are refused outright when the divider is not built.
    assign accept = start && (state == IDLE) && (DIV_EN || !op[1]);
    assign last   = (cnt == CW'(SIZE - 1));

    assign sa    = op[0] & A[SIZE-1];
    assign sb    = op[0] & B[SIZE-1];
    assign mag_a = sa ? -A : A;
    assign mag_b = sb ? -B : B;

    always_comb begin
        // Shift-add step: add multiplicand when the current multiplier
        // bit is set, then shift the whole accumulator right by one.
        sum    = {1'b0, acc[2*SIZE-1:SIZE]} + (acc[0] ? {1'b0, mcand} : {(SIZE+1){1'b0}});
        acc_nx = {sum, acc[SIZE-1:1]};
        prod   = neg_res ? -acc_nx : acc_nx;
        res_hi = prod[2*SIZE-1:SIZE];
        res_lo = prod[SIZE-1:0];
`ifdef MULTDIV_DIV_EN
        // Restoring step: bring in the next dividend bit and subtract the
        // divisor only if it fits. The difference is below the divisor,
        // so SIZE bits hold it.
        shifted = {rem, acc[SIZE-1]};
        ge      = (shifted >= {1'b0, mcand});
        rem_nx  = ge ? (shifted[SIZE-1:0] - mcand) : shifted[SIZE-1:0];
        q_nx    = {acc[SIZE-2:0], ge};
        res_dz  = is_div & b_zero;
        if (is_div) begin
            res_lo = neg_res ? -q_nx : q_nx;
            res_hi = neg_rem ? -rem_nx : rem_nx;
            if (b_zero) begin
                res_lo = '1;
                res_hi = a_raw;
            end
        end
`endif
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            cnt     <= '0;
            acc     <= '0;
            mcand   <= '0;
            neg_res <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            hi      <= '0;
            lo      <= '0;
`ifdef MULTDIV_DIV_EN
            is_div  <= 1'b0;
            neg_rem <= 1'b0;
            b_zero  <= 1'b0;
            a_raw   <= '0;
            rem     <= '0;
            divzero <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        state   <= RUN;
                        busy    <= 1'b1;
                        cnt     <= '0;
                        acc     <= {{SIZE{1'b0}}, (op[1] ? mag_a : mag_b)};
                        mcand   <= op[1] ? mag_b : mag_a;
                        neg_res <= sa ^ sb;
`ifdef MULTDIV_DIV_EN
                        is_div  <= op[1];
                        neg_rem <= sa;
                        b_zero  <= (B == '0);
                        a_raw   <= A;
                        rem     <= '0;
`endif
                    end
                end
                RUN: begin
                    cnt <= cnt + 1'b1;
`ifdef MULTDIV_DIV_EN
                    acc <= is_div ? {acc[2*SIZE-1:SIZE], q_nx} : acc_nx;
                    rem <= rem_nx;
`else
                    acc <= acc_nx;
`endif
                    if (last) begin
                        state   <= IDLE;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        hi      <= res_hi;
                        lo      <= res_lo;
`ifdef MULTDIV_DIV_EN
                        divzero <= res_dz;
`endif
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifndef MULTDIV_DIV_EN
    assign divzero = 1'b0;
`endif

endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit: directed + randomized bench for mult_div_unit (SIZE=32).
// Reference results come from plain 64-bit arithmetic on the operands.
module tb_mult_div_unit;
    localparam int SIZE = 32;

    logic            clk = 1'b0;
    logic            reset;
    logic            start;
    logic [1:0]      op;
    logic [SIZE-1:0] A, B;
    logic            busy, done, divzero;
    logic [SIZE-1:0] hi, lo;

    int errors = 0;
    int checks = 0;

    // Expected architectural HI/LO/divzero after the last completed op.
    logic [31:0] m_hi = '0, m_lo = '0;
    logic        m_dz = 1'b0;

    mult_div_unit #(.SIZE(SIZE)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .A(A), .B(B),
        .busy(busy), .done(done), .hi(hi), .lo(lo), .divzero(divzero)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
        checks++;
        assert (got === want) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask

    function automatic void model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] h, output logic [31:0] l, output logic z);
        longint      sa, sb, q, r;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        z  = 1'b0;
        h  = '0;
        l  = '0;
        case (o)
            2'd0: begin p = {32'd0, a} * {32'd0, b}; h = p[63:32]; l = p[31:0]; end
            2'd1: begin p = sa * sb;                 h = p[63:32]; l = p[31:0]; end
            default: begin
                if (b == 0) begin
                    l = 32'hFFFF_FFFF; h = a; z = 1'b1;
                end else if (o == 2'd2) begin
                    l = a / b; h = a % b;
                end else begin
                    q = sa / sb; r = sa % sb;   // truncating division, remainder keeps dividend sign
                    l = q[31:0]; h = r[31:0];
                end
            end
        endcase
    endfunction

    // Issues one op at the current time (just after a posedge) and returns
    // just after its done edge. Calling it again immediately is back-to-back.
    task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] a,
                          input logic [31:0] b, input bit pulse);
        bit run_ok;
        model(o, a, b, m_hi, m_lo, m_dz);
        op = o; A = a; B = b; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        A = $urandom; B = $urandom; op = 2'($urandom);   // must not disturb the op in flight
        run_ok = (busy === 1'b1) && (done === 1'b0);
        for (int i = 1; i < SIZE; i++) begin
            if (pulse && i == 4) begin
                start = 1'b1; op = 2'd0; A = 32'd3; B = 32'd3;
            end
            @(posedge clk); #1;
            start = 1'b0;
            if (busy !== 1'b1 || done !== 1'b0) run_ok = 1'b0;
        end
        check({tag, "_busy_run"}, 64'(run_ok), 64'd1);
        @(posedge clk); #1;
        check({tag, "_done"}, {62'd0, done, busy}, 64'b10);
        check({tag, "_hilo"}, {hi, lo}, {m_hi, m_lo});
        check({tag, "_dz"}, 64'(divzero), 64'(m_dz));
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin @(posedge clk); #1; end
    endtask

    // Watches n cycles for any done pulse or busy; both must stay low.
    task automatic quiet(input string tag, input int n);
        bit ok = 1'b1;
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            start = 1'b0;
            if (done !== 1'b0 || busy !== 1'b0) ok = 1'b0;
        end
        check({tag, "_quiet"}, 64'(ok), 64'd1);
    endtask

    initial begin
        logic [1:0]  o;
        logic [31:0] a, b;
        reset = 1'b0; start = 1'b0; op = '0; A = '0; B = '0;
        #1;
        check("reset_state", {busy, done, divzero, hi, lo}, '0);
        @(negedge clk); reset = 1'b1;
        @(posedge clk); #1;

        // Test-plan vectors.
        run_op("multu_max", 2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        check("multu_max_const", {hi, lo}, 64'hFFFF_FFFE_0000_0001);
        @(posedge clk); #1;
        check("done_one_cycle", 64'(done), 64'd0);
        run_op("mult_neg", 2'd1, 32'hFFFF_FFFD, 32'd7, 1'b0);
        check("mult_neg_const", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFEB);

        // Start pulsed mid-run is ignored: one done, then silence.
        run_op("pulse", 2'd0, 32'h1234_5678, 32'h9ABC_DEF0, 1'b1);
        quiet("pulse_after", SIZE + 4);

        // Back-to-back: second start issued during the done cycle.
        run_op("b2b_1", 2'd1, 32'h8000_0000, 32'h8000_0000, 1'b0);
        run_op("b2b_2", 2'd0, 32'd0, 32'hDEAD_BEEF, 1'b0);

        // Random multiplies, some back-to-back and some with idle gaps.
        for (int i = 0; i < 8; i++) begin
            o = 2'($urandom_range(0, 1)); a = $urandom; b = $urandom;
            run_op("rnd_mul", o, a, b, 1'b0);
            if (i[0]) idle_cycles(int'($urandom_range(1, 3)));
        end

`ifdef MULTDIV_DIV_EN
        run_op("divu", 2'd2, 32'd100, 32'd7, 1'b0);
        check("divu_const", {hi, lo}, {32'd2, 32'd14});
        run_op("div_neg", 2'd3, 32'hFFFF_FFF9, 32'd2, 1'b0);
        check("div_neg_const", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);
        run_op("div_ovf", 2'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        check("div_ovf_const", {divzero, hi, lo}, {1'b0, 32'd0, 32'h8000_0000});
        run_op("divu_zero", 2'd2, 32'd5, 32'd0, 1'b0);
        check("divu_zero_const", {divzero, hi, lo}, {1'b1, 32'd5, 32'hFFFF_FFFF});
        run_op("dz_clear", 2'd0, 32'd2, 32'd3, 1'b0);
        check("dz_clear_const", 64'(divzero), 64'd0);
        for (int i = 0; i < 10; i++) begin
            o = 2'($urandom_range(2, 3)); a = $urandom;
            case (i % 3)
                0: b = $urandom;
                1: b = 32'($urandom_range(0, 9));
                default: b = -32'($urandom_range(0, 9));
            endcase
            run_op("rnd_div", o, a, b, 1'b0);
        end
`else
        run_op("pre_divu", 2'd0, 32'h0001_0000, 32'h0003_0005, 1'b0);
        idle_cycles(1);
        op = 2'd2; A = 32'd100; B = 32'd7; start = 1'b1;
        quiet("divu_off", 6);
        check("divu_off_hilo", {divzero, hi, lo}, {1'b0, m_hi, m_lo});
        op = 2'd3; A = 32'd9; B = 32'd0; start = 1'b1;
        quiet("div_off", 4);
        check("div_off_hilo", {divzero, hi, lo}, {1'b0, m_hi, m_lo});
        run_op("mul_after", 2'd0, 32'd6, 32'd7, 1'b0);
        check("mul_after_const", {hi, lo}, 64'd42);
`endif

        // Reset mid-run clears outputs asynchronously; no done follows.
        idle_cycles(1);
        op = 2'd1; A = 32'hFFFF_0001; B = 32'h0000_7777; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        idle_cycles(10);
        #2 reset = 1'b0;
        #1;
        check("async_reset", {busy, done, divzero, hi, lo}, '0);
        @(negedge clk); @(negedge clk); reset = 1'b1;
        m_hi = '0; m_lo = '0; m_dz = 1'b0;
        quiet("after_reset", SIZE + 4);
        check("after_reset_hilo", {hi, lo}, {m_hi, m_lo});

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
